// File: rtl/reg_file_32x32_sync.sv
// 32 x 32-bit register file: one write port, two registered read ports with write-through bypass.
// Define REG_ZERO_HARDWIRE_EN to make register 0 a constant zero.
module reg_file_32x32_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en_p0;
    logic [DATA_WIDTH-1:0] rd1_p0;
    logic [DATA_WIDTH-1:0] rd2_p0;
    logic [DATA_WIDTH-1:0] rd1_p1;
    logic [DATA_WIDTH-1:0] rd2_p1;
    logic                  vld_p1;

    // With the hardwired zero register, a write to address 0 is dropped
    // entirely, so it can neither update regs[0] nor feed the bypass.
`ifdef REG_ZERO_HARDWIRE_EN
    assign wr_en_p0 = WRITE && (ADDR_W != '0);
`else
    assign wr_en_p0 = WRITE;
`endif

    // Stage p0: per-port 32:1 select with write-through bypass
    always_comb begin
        rd1_p0 = regs[ADDR_R1];
        rd2_p0 = regs[ADDR_R2];
        if (wr_en_p0 && (ADDR_W == ADDR_R1)) begin
            rd1_p0 = DATA_W;
        end
        if (wr_en_p0 && (ADDR_W == ADDR_R2)) begin
            rd2_p0 = DATA_W;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_p0) begin
            regs[ADDR_W] <= DATA_W;
        end
    end

    // Stage p1: registered read data and valid strobe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd1_p1 <= '0;
            rd2_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= READ;
            if (READ) begin
                rd1_p1 <= rd1_p0;
                rd2_p1 <= rd2_p0;
            end
        end
    end

    assign DATA_R1  = rd1_p1;
    assign DATA_R2  = rd2_p1;
    assign RD_VALID = vld_p1;

endmodule

// File: tb/tb_reg_file_32x32_sync.sv
// Randomized self-checking bench for reg_file_32x32_sync against an array-based reference model.
// Honors REG_ZERO_HARDWIRE_EN the same way the design does.
module tb_reg_file_32x32_sync;

`ifdef REG_ZERO_HARDWIRE_EN
    localparam bit HW0 = 1'b1;
`else
    localparam bit HW0 = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [4:0]  ADDR_R1 = '0;
    logic [4:0]  ADDR_R2 = '0;
    logic [4:0]  ADDR_W = '0;
    logic [31:0] DATA_W = '0;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        RD_VALID;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [32];
    logic [31:0] exp1 = '0;
    logic [31:0] exp2 = '0;
    logic        evld = 1'b0;

    reg_file_32x32_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .RD_VALID(RD_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input bit wr,
                                             input logic [4:0] aw, input logic [31:0] dw);
        if (HW0 && a == 5'd0) return 32'h0;
        if (wr && aw == a) return dw;
        return mem[a];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        exp1 = '0;
        exp2 = '0;
        evld = 1'b0;
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, check 1 ns later.
    task automatic cyc(input bit rd, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic [31:0] dw, input string tag);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        @(posedge CLK);
        if (rd) begin
            exp1 = mdl_read(a1, wr, aw, dw);
            exp2 = mdl_read(a2, wr, aw, dw);
        end
        evld = rd;
        if (wr && !(HW0 && aw == 5'd0)) mem[aw] = dw;
        #1;
        chk({tag, "_r1"}, DATA_R1, exp1);
        chk({tag, "_r2"}, DATA_R2, exp2);
        chk({tag, "_vld"}, {31'b0, RD_VALID}, {31'b0, evld});
    endtask

    initial begin
        mdl_clear();
        // Reset with arbitrary inputs applied
        READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd31; ADDR_W = 5'd5;
        DATA_W = $urandom;
        #1 RST = 1'b0;
        #1;
        chk("rst_r1", DATA_R1, 32'h0);
        chk("rst_r2", DATA_R2, 32'h0);
        chk("rst_vld", {31'b0, RD_VALID}, 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1; READ = 1'b0; WRITE = 1'b0;
        cyc(1, 0, 5'd5, 5'd31, 5'd0, 32'h0, "rst_read");
        chk("rst_read_a5", DATA_R1, 32'h0);
        chk("rst_read_a31", DATA_R2, 32'h0);

        // Fill and readback
        for (int i = 0; i < 32; i++) cyc(0, 1, 5'd0, 5'd0, 5'(i), 32'h100 + i, "fill");
        cyc(1, 0, 5'd3, 5'd27, 5'd0, 32'h0, "rb");
        chk("rb_a3", DATA_R1, 32'h103);
        chk("rb_a27", DATA_R2, 32'h11B);
        chk("rb_vld", {31'b0, RD_VALID}, 32'h1);
        for (int i = 0; i < 32; i++) cyc(1, 0, 5'(i), 5'(31 - i), 5'd0, 32'h0, "sweep");

        // Write-through bypass on port 1, plain read on port 2
        cyc(0, 1, 5'd0, 5'd0, 5'd9, 32'hAAAA0000, "byp_pre");
        cyc(1, 1, 5'd9, 5'd4, 5'd9, 32'h12345678, "byp");
        chk("byp_r1", DATA_R1, 32'h12345678);
        chk("byp_r2", DATA_R2, 32'h104);
        cyc(1, 1, 5'd20, 5'd20, 5'd20, 32'hCAFEF00D, "byp_both");
        chk("byp_both_r2", DATA_R2, 32'hCAFEF00D);

        // Hold while idle
        cyc(1, 0, 5'd12, 5'd13, 5'd0, 32'h0, "hold_rd");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 5'd1, 5'd2, 5'd12, 32'hDEADBEEF, "hold");
            chk("hold_x12", DATA_R1, 32'h10C);
        end
        cyc(1, 0, 5'd12, 5'd12, 5'd0, 32'h0, "hold_new");
        chk("hold_new_r1", DATA_R1, 32'hDEADBEEF);

        // Reset asserted mid-cycle during a write to address 7
        @(negedge CLK);
        WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'hFFFFFFFF; READ = 1'b1; ADDR_R1 = 5'd7;
        #2 RST = 1'b0;
        #1;
        chk("midrst_r1", DATA_R1, 32'h0);
        chk("midrst_r2", DATA_R2, 32'h0);
        chk("midrst_vld", {31'b0, RD_VALID}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1; WRITE = 1'b0; READ = 1'b0;
        mdl_clear();
        cyc(1, 0, 5'd7, 5'd12, 5'd0, 32'h0, "midrst_rd");
        chk("midrst_a7", DATA_R1, 32'h0);

        // Zero register write with same-cycle read
        cyc(1, 1, 5'd0, 5'd0, 5'd0, 32'h5A5A5A5A, "zero");
        chk("zero_r1", DATA_R1, HW0 ? 32'h0 : 32'h5A5A5A5A);
        cyc(1, 0, 5'd0, 5'd1, 5'd0, 32'h0, "zero_rb");
        chk("zero_rb_r1", DATA_R1, HW0 ? 32'h0 : 32'h5A5A5A5A);

        // Randomized traffic, addresses biased toward collisions
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a1, a2, aw;
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            aw = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            cyc(1'($urandom), 1'($urandom), a1, a2, aw, $urandom, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
